// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce / edge-detect conditioning stage.
// Optional build macro: DEBOUNCE_GLITCH_COUNT_EN (adds a rejected-glitch counter).
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_CNT_W         = 8;
   localparam int MAX_CNT_W         = 32;

   // Counters are widened to MAX_CNT_W for the call; w is the real width,
   // so the ceiling is 2^w-1 and the value holds there once reached.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                    input int unsigned         w);
      logic [MAX_CNT_W-1:0] lim;
      lim = (w >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << w) - MAX_CNT_W'(1));
      return (v >= lim) ? v : v + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop synchroniser for a single asynchronous bit; contents cleared by sync_reset.
module sync_nff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic sync_reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (sync_reset) ff <= '0;
      else            ff <= {ff[STAGES-2:0], din};
   end

   assign dout = ff[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronise + stable-time debounce of a raw input, with rise/fall strobes and
// saturating edge counter. DEBOUNCE_GLITCH_COUNT_EN adds glitch_count.
module debounce_edge_detect
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             din,
   input  logic             clr_count,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_count
`ifdef DEBOUNCE_GLITCH_COUNT_EN
   ,
   output logic [CNT_W-1:0] glitch_count
`endif
);

   localparam int TW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(STABLE_CYCLES - 1);

   logic          din_s;
   state_t        state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic          level_d, rise_d, fall_d, edge_inc;

   sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .sync_reset (sync_reset),
      .din        (din),
      .dout       (din_s)
   );

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state <= S_LOW;
         timer <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_d;
         timer <= timer_d;
         level <= level_d;
         rise  <= rise_d;
         fall  <= fall_d;
      end
   end

   // The timer counts din_s samples already seen at the candidate level;
   // acceptance happens on the STABLE_CYCLES-th consecutive sample.
   always_comb begin
      state_d  = state;
      timer_d  = timer;
      level_d  = level;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      edge_inc = 1'b0;
      case (state)
         S_LOW: begin
            if (din_s) begin
               state_d = S_WAIT_H;
               timer_d = TW'(1);
            end
         end
         S_WAIT_H: begin
            if (!din_s) begin
               state_d = S_LOW;
               timer_d = '0;
            end else if (timer == T_LAST) begin
               state_d  = S_HIGH;
               timer_d  = '0;
               level_d  = 1'b1;
               rise_d   = 1'b1;
               edge_inc = 1'b1;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         S_HIGH: begin
            if (!din_s) begin
               state_d = S_WAIT_L;
               timer_d = TW'(1);
            end
         end
         S_WAIT_L: begin
            if (din_s) begin
               state_d = S_HIGH;
               timer_d = '0;
            end else if (timer == T_LAST) begin
               state_d  = S_LOW;
               timer_d  = '0;
               level_d  = 1'b0;
               fall_d   = 1'b1;
               edge_inc = 1'b1;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            timer_d = '0;
         end
      endcase
   end

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (sync_reset || clr_count) edge_count <= '0;
      else if (edge_inc)           edge_count <= CNT_W'(sat_inc(MAX_CNT_W'(edge_count), CNT_W));
   end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
   logic glitch_inc;
   assign glitch_inc = ((state == S_WAIT_H) && !din_s) || ((state == S_WAIT_L) && din_s);

   always_ff @(posedge clk) begin
      if (sync_reset || clr_count) glitch_count <= '0;
      else if (glitch_inc)         glitch_count <= CNT_W'(sat_inc(MAX_CNT_W'(glitch_count), CNT_W));
   end
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Scoreboarded directed bench: stimulus pushes expected strobes (kind + cycle),
// a negedge monitor pops and compares whenever rise/fall is presented.
module tb_debounce_edge_detect;

   logic       clk = 1'b0;
   logic       sync_reset = 1'b0;
   logic       din = 1'b0;
   logic       clr_count = 1'b0;
   logic       level, rise, fall;
   logic [7:0] edge_count;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
   logic [7:0] glitch_count;
`endif

   logic       din2 = 1'b0;
   logic       level2, rise2, fall2;
   logic [2:0] edge_count2;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
   logic [2:0] glitch_count2;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit is_rise;
      int cyc;
   } exp_t;
   exp_t q[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .din        (din),
      .clr_count  (clr_count),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .edge_count (edge_count)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      ,
      .glitch_count (glitch_count)
`endif
   );

   debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(3)) u_sat (
      .clk        (clk),
      .sync_reset (sync_reset),
      .din        (din2),
      .clr_count  (clr_count),
      .level      (level2),
      .rise       (rise2),
      .fall       (fall2),
      .edge_count (edge_count2)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      ,
      .glitch_count (glitch_count2)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_strobe(input bit r, input int at);
      exp_t e;
      e.is_rise = r;
      e.cyc     = at;
      q.push_back(e);
   endtask

   // Strobe monitor for the main DUT.
   always @(negedge clk) begin
      exp_t e;
      if (rise && fall) begin
         total++; bad++;
         $display("FAIL both_strobes: rise=%0b fall=%0b at cycle %0d, required not both", rise, fall, cyc);
      end else if (rise || fall) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: rise=%0b fall=%0b at cycle %0d, none expected", rise, fall, cyc);
         end else begin
            e = q.pop_front();
            if (e.is_rise != rise || e.cyc != cyc) begin
               bad++;
               $display("FAIL strobe: rise=%0b at cycle %0d, expected rise=%0b at cycle %0d",
                        rise, cyc, e.is_rise, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: cycle %0d reached, expected finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // Reset held with din=1, then release.
      din = 1'b1; sync_reset = 1'b1;
      step(3);
      chk("rst_level", int'(level), 0);
      chk("rst_rise", int'(rise), 0);
      chk("rst_fall", int'(fall), 0);
      chk("rst_edge_count", int'(edge_count), 0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      chk("rst_glitch_count", int'(glitch_count), 0);
`endif
      sync_reset = 1'b0;
      k = cyc;
      expect_strobe(1'b1, k + 6);
      step(5);
      chk("post_rst_level_held_low", int'(level), 0);
      step(1);
      chk("post_rst_level_high", int'(level), 1);
      chk("post_rst_edge_count", int'(edge_count), 1);
      step(1);
      chk("rise_one_cycle", int'(rise), 0);

      // Clean edges.
      clr_count = 1'b1; step(1); clr_count = 1'b0;
      chk("clr_edge_count", int'(edge_count), 0);
      chk("clr_keeps_level", int'(level), 1);
      din = 1'b0; expect_strobe(1'b0, cyc + 6); step(10);
      din = 1'b1; expect_strobe(1'b1, cyc + 6); step(10);
      chk("clean_edge_count2", int'(edge_count), 2);
      chk("clean_level_high", int'(level), 1);
      din = 1'b0; expect_strobe(1'b0, cyc + 6); step(10);
      chk("clean_edge_count3", int'(edge_count), 3);
      chk("clean_level_low", int'(level), 0);

      // Glitches: 2 and 3 samples rejected, 4 samples accepted.
      clr_count = 1'b1; step(1); clr_count = 1'b0;
      din = 1'b1; step(2); din = 1'b0; step(10);
      chk("glitch2_level", int'(level), 0);
      chk("glitch2_edge_count", int'(edge_count), 0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      chk("glitch2_glitch_count", int'(glitch_count), 1);
`endif
      din = 1'b1; step(3); din = 1'b0; step(10);
      chk("glitch3_level", int'(level), 0);
      chk("glitch3_edge_count", int'(edge_count), 0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      chk("glitch3_glitch_count", int'(glitch_count), 2);
`endif
      k = cyc;
      din = 1'b1; expect_strobe(1'b1, k + 6); step(4);
      din = 1'b0; expect_strobe(1'b0, k + 10); step(12);
      chk("pulse4_edge_count", int'(edge_count), 2);

      // Clear on the same edge as rise.
      k = cyc;
      din = 1'b1; expect_strobe(1'b1, k + 6); step(5);
      clr_count = 1'b1; step(1); clr_count = 1'b0;
      chk("collide_edge_count", int'(edge_count), 0);
      chk("collide_rise", int'(rise), 1);
      chk("collide_level", int'(level), 1);
      step(4);

      // Reset mid-filter with timer=2 in S_WAIT_H.
      din = 1'b0; expect_strobe(1'b0, cyc + 6); step(10);
      din = 1'b1; step(4);
      sync_reset = 1'b1; step(1); sync_reset = 1'b0;
      chk("midrst_level", int'(level), 0);
      chk("midrst_rise", int'(rise), 0);
      chk("midrst_edge_count", int'(edge_count), 0);
      expect_strobe(1'b1, cyc + 6);
      step(5);
      chk("midrst_level_held_low", int'(level), 0);
      step(1);
      chk("midrst_level_high", int'(level), 1);
      chk("midrst_edge_count1", int'(edge_count), 1);
      step(2);

      // Saturation on the 3-bit instance.
      for (int i = 1; i <= 9; i++) begin
         din2 = ~din2;
         step(10);
         chk($sformatf("sat_edge_%0d", i), int'(edge_count2), (i > 7) ? 7 : i);
      end

      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
